// File: rtl/regfile_pkg.sv
// Shared register-file constants and the write-request record used around the
// regfile write port.
package regfile_pkg;

  localparam int REG_COUNT      = 32;
  localparam int REG_ADDR_WIDTH = $clog2(REG_COUNT);
  localparam int REG_DATA_WIDTH = 32;
  localparam int ZERO_REG       = 0;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] addr;
    logic [REG_DATA_WIDTH-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match search over the pending write entries.
// The scan starts at the tail slot and walks forward around the ring. The tail
// slot holds the oldest entry when the buffer is full and is invalid otherwise,
// so the last valid match seen in the scan is the youngest one.
module wb_fwd_match
  import regfile_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int PTR_W      = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]      valid_i,
  input  logic [ADDR_WIDTH-1:0] addr_i [DEPTH],
  input  logic [DATA_WIDTH-1:0] data_i [DEPTH],
  input  logic [PTR_W-1:0]      tail_i,
  input  logic [ADDR_WIDTH-1:0] fwd_addr_i,
  output logic                  hit_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

  logic [PTR_W-1:0] idx;

  // Scan oldest-to-youngest; later matches overwrite earlier ones.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = tail_i + PTR_W'(i);
      if (valid_i[idx] && (addr_i[idx] == fwd_addr_i) && (fwd_addr_i != ZERO_ADDR)) begin
        hit_o  = 1'b1;
        data_o = data_i[idx];
      end
    end
  end

endmodule

// File: rtl/regfile_write_buffer.sv
// In-order write-back buffer feeding the register-file write port.
// Accepts writes over valid/ready, drains one entry per cycle (the regfile
// never stalls), and forwards the youngest pending value for a read address.
module regfile_write_buffer
  import regfile_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = REG_DATA_WIDTH,
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_WIDTH-1:0]   in_addr,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    ctrl_writeEnable,
  output logic [ADDR_WIDTH-1:0]   ctrl_writeReg,
  output logic [DATA_WIDTH-1:0]   data_writeReg,
  input  logic [ADDR_WIDTH-1:0]   fwd_addr,
  output logic                    fwd_hit,
  output logic [DATA_WIDTH-1:0]   fwd_data,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]      FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic                  push;
  logic                  pop;

  // Ready depends only on registered occupancy; writes to r0 are swallowed.
  assign in_ready = (count_q < FULL_CNT);
  assign pop      = (count_q != '0);
  assign push     = in_valid && in_ready && (in_addr != ZERO_ADDR);

  // Next-state for pointers, occupancy and per-entry valid bits.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Control state: asynchronous reset discards every pending write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Entry payload storage; never read without its valid/occupancy qualifier.
  always_ff @(posedge clock) begin
    if (push) begin
      addr_q[tail_q] <= in_addr;
      data_q[tail_q] <= in_data;
    end
  end

  // Head entry drives the regfile port; zeroed when nothing is pending.
  assign ctrl_writeEnable = pop;
  assign ctrl_writeReg    = pop ? addr_q[head_q] : '0;
  assign data_writeReg    = pop ? data_q[head_q] : '0;
  assign count            = count_q;

  wb_fwd_match #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .PTR_W      (PTR_W)
  ) u_fwd (
    .valid_i    (valid_q),
    .addr_i     (addr_q),
    .data_i     (data_q),
    .tail_i     (tail_q),
    .fwd_addr_i (fwd_addr),
    .hit_o      (fwd_hit),
    .data_o     (fwd_data)
  );

endmodule

// File: tb/tb_regfile_write_buffer.sv
// Directed bench for regfile_write_buffer with a scoreboard of pending writes.
module tb_regfile_write_buffer;
  import regfile_pkg::*;

  localparam int DEPTH = 4;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  fwd_addr;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [2:0]  count;

  wr_req_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  regfile_write_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clock            (clock),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_addr          (in_addr),
    .in_data          (in_data),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .fwd_addr         (fwd_addr),
    .fwd_hit          (fwd_hit),
    .fwd_data         (fwd_data),
    .count            (count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Youngest pending write to address a; bit 32 is the hit flag.
  function automatic logic [32:0] model_fwd(input logic [4:0] a);
    logic [32:0] r;
    r = '0;
    if (a != 5'd0) begin
      foreach (exp_q[i]) begin
        if (exp_q[i].addr == a) r = {1'b1, exp_q[i].data};
      end
    end
    return r;
  endfunction

  // One clock cycle: check current state against the scoreboard, drive the
  // request, account for the commit/accept at the coming edge, then advance.
  task automatic cyc(input logic v, input logic [4:0] a, input logic [31:0] d);
    logic [32:0] m;
    logic        acc;
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    #1;
    m = model_fwd(fwd_addr);
    chk("count", 64'(count), 64'(exp_q.size()));
    chk("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
    chk("wr_en", 64'(ctrl_writeEnable), 64'(exp_q.size() != 0));
    chk("fwd_hit", 64'(fwd_hit), 64'(m[32]));
    chk("fwd_data", 64'(fwd_data), 64'(m[31:0]));
    acc = v && (exp_q.size() < DEPTH) && (a != 5'd0);
    if (exp_q.size() != 0) begin
      chk("wr_reg", 64'(ctrl_writeReg), 64'(exp_q[0].addr));
      chk("wr_data", 64'(data_writeReg), 64'(exp_q[0].data));
      void'(exp_q.pop_front());
    end else begin
      chk("wr_reg_idle", 64'(ctrl_writeReg), 64'd0);
      chk("wr_data_idle", 64'(data_writeReg), 64'd0);
    end
    if (acc) exp_q.push_back('{addr: a, data: d});
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_en"}, 64'(ctrl_writeEnable), 64'd0);
    chk({tag, "_reg"}, 64'(ctrl_writeReg), 64'd0);
    chk({tag, "_data"}, 64'(data_writeReg), 64'd0);
    chk({tag, "_hit"}, 64'(fwd_hit), 64'd0);
    chk({tag, "_fdata"}, 64'(fwd_data), 64'd0);
    chk({tag, "_count"}, 64'(count), 64'd0);
  endtask

  initial begin
    int budget;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_addr  = '0;
    in_data  = '0;
    fwd_addr = '0;

    // Outputs while held in reset, then release between edges.
    #2;
    chk_reset_outputs("in_reset");
    #10;
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Idle after reset.
    for (int i = 0; i < 3; i++) cyc(1'b0, 5'd0, 32'd0);
    chk_reset_outputs("idle");

    // Single push: visible on the port one cycle later, gone the cycle after.
    cyc(1'b1, 5'd5, 32'hDEADBEEF);
    chk("single_en", 64'(ctrl_writeEnable), 64'd1);
    chk("single_reg", 64'(ctrl_writeReg), 64'd5);
    chk("single_data", 64'(data_writeReg), 64'hDEADBEEF);
    chk("single_count", 64'(count), 64'd1);
    cyc(1'b0, 5'd0, 32'd0);
    chk("single_after_count", 64'(count), 64'd0);
    chk("single_after_en", 64'(ctrl_writeEnable), 64'd0);

    // Back-to-back stream of five writes with valid held high.
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b1, 5'(i), 32'(i * 32'h11));
      chk("b2b_count_le_depth", 64'(count <= 3'(DEPTH)), 64'd1);
    end
    budget = 0;
    while (exp_q.size() != 0 && budget < 20) begin
      cyc(1'b0, 5'd0, 32'd0);
      budget++;
    end
    chk("b2b_drained", 64'(exp_q.size()), 64'd0);
    cyc(1'b0, 5'd0, 32'd0);

    // Repeated writes to one address: forwarding follows the youngest.
    fwd_addr = 5'd7;
    cyc(1'b1, 5'd7, 32'h1);
    chk("fwd_first_hit", 64'(fwd_hit), 64'd1);
    chk("fwd_first_data", 64'(fwd_data), 64'h1);
    cyc(1'b1, 5'd7, 32'h2);
    chk("fwd_second_hit", 64'(fwd_hit), 64'd1);
    chk("fwd_second_data", 64'(fwd_data), 64'h2);
    cyc(1'b0, 5'd0, 32'd0);
    chk("fwd_gone", 64'(fwd_hit), 64'd0);
    chk("fwd_gone_data", 64'(fwd_data), 64'd0);

    // Writes to register 0 are consumed but never enqueued or forwarded.
    fwd_addr = 5'd0;
    cyc(1'b1, 5'd0, 32'hFFFFFFFF);
    chk("r0_count", 64'(count), 64'd0);
    chk("r0_en", 64'(ctrl_writeEnable), 64'd0);
    chk("r0_hit", 64'(fwd_hit), 64'd0);
    cyc(1'b0, 5'd0, 32'd0);

    // Asynchronous reset in the middle of a cycle with writes pending.
    fwd_addr = 5'd4;
    cyc(1'b1, 5'd3, 32'hA);
    cyc(1'b1, 5'd4, 32'hB);
    chk("pre_reset_hit", 64'(fwd_hit), 64'd1);
    in_valid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    exp_q.delete();
    #3;
    reset = 1'b0;
    @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) cyc(1'b0, 5'd0, 32'd0);

    // Buffer still works after the mid-operation reset.
    fwd_addr = 5'd9;
    cyc(1'b1, 5'd9, 32'h12345678);
    chk("post_reset_reg", 64'(ctrl_writeReg), 64'd9);
    cyc(1'b0, 5'd0, 32'd0);
    cyc(1'b0, 5'd0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
